// File: rtl/sar_pkg.sv
// -----------------------------------------------------------------------------
// sar_pkg
// Shared types and constants for the SAR controller.
//   sar_state_t : controller state encoding
//   CAP_BUS_W   : width of each capacitor-array bottom-plate bus
//   cnt_width() : counter width able to hold values 0..max_val
// -----------------------------------------------------------------------------
package sar_pkg;

  localparam int CAP_BUS_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_SETTLE,
    ST_STROBE,
    ST_WAIT,
    ST_DONE
  } sar_state_t;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sar_cnt.sv
// -----------------------------------------------------------------------------
// sar_cnt
// Generic down-counter. Loads on load, decrements on en, and stops at zero.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (count cleared)
//   load      : load load_val (wins over en)
//   en        : decrement by one while non-zero
//   load_val  : W-bit reload value
//   zero      : count is zero
// -----------------------------------------------------------------------------
module sar_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: state in always_ff uses non-blocking (<=) only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sar_logic.sv
// -----------------------------------------------------------------------------
// sar_logic
// Synchronous SAR controller for a capacitive DAC array and comparator.
// Samples the input, then resolves N_BITS bits MSB first: each bit is set as a
// trial, the DAC settles, the comparator is strobed and its decision keeps or
// clears the trial bit. The code is returned over a valid/ready handshake.
//
// Optional feature (macro SAR_CMP_TIMEOUT_EN): comparator watchdog. After
// TIMEOUT_CYCLES in WAIT without cmp_valid the bit resolves to 0 and the
// sticky cmp_timeout flag is raised.
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   start              : conversion request, accepted only in IDLE
//   busy               : high in every state except IDLE
//   samp_en            : sampling-switch enable
//   cap_botplate_main  : main-array bottom-plate drive (SAR code)
//   cap_botplate_diff  : diff-array bottom-plate drive (complement of code)
//   cmp_clk            : one-cycle comparator strobe
//   cmp_valid, cmp_out : comparator decision handshake (1 = keep trial bit)
//   dout, dout_valid   : conversion result, valid held until dout_ready
//   dout_ready         : result consumer ready
//   cmp_timeout        : sticky watchdog flag (SAR_CMP_TIMEOUT_EN only)
// -----------------------------------------------------------------------------
module sar_logic
  import sar_pkg::*;
#(
  parameter int N_BITS         = 16,
  parameter int SAMPLE_CYCLES  = 4,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 samp_en,
  output logic [CAP_BUS_W-1:0] cap_botplate_main,
  output logic [CAP_BUS_W-1:0] cap_botplate_diff,
  output logic                 cmp_clk,
  input  logic                 cmp_valid,
  input  logic                 cmp_out,
  output logic [N_BITS-1:0]    dout,
  output logic                 dout_valid,
  input  logic                 dout_ready
`ifdef SAR_CMP_TIMEOUT_EN
  ,
  output logic                 cmp_timeout
`endif
);

  // One counter width serves every phase count.
  localparam int PHASE_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_MAX   = (PHASE_MAX > TIMEOUT_CYCLES) ? PHASE_MAX : TIMEOUT_CYCLES;
  localparam int CNT_W     = cnt_width(CNT_MAX);
  localparam int IDX_W     = cnt_width(N_BITS - 1);

  // Counters stop on zero, so load "cycles - 1". SETTLE_CYCLES=0 still spends
  // one cycle in SETTLE.
  localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] MSB_IDX     = IDX_W'(N_BITS - 1);

  sar_state_t        state, next_state;
  logic [N_BITS-1:0] sar;
  logic [N_BITS-1:0] sar_decided;
  logic [N_BITS-1:0] sar_stepped;
  logic [IDX_W-1:0]  bit_idx;
  logic              phase_load;
  logic [CNT_W-1:0]  phase_val;
  logic              phase_en;
  logic              phase_zero;
  logic              expire;
  logic              decide;
  logic              bit_val;
  logic              drive_plates;

  // ---------------------------------------------------------------------------
  // Phase counter: SAMPLE and SETTLE durations
  // ---------------------------------------------------------------------------
  assign phase_en = (state == ST_SAMPLE) || (state == ST_SETTLE);

  sar_cnt #(.W(CNT_W)) u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (phase_load),
    .en       (phase_en),
    .load_val (phase_val),
    .zero     (phase_zero)
  );

  // ---------------------------------------------------------------------------
  // Comparator watchdog
  // ---------------------------------------------------------------------------
`ifdef SAR_CMP_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  logic to_zero;

  sar_cnt #(.W(CNT_W)) u_timeout_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ST_STROBE),
    .en       (state == ST_WAIT),
    .load_val (TIMEOUT_LOAD),
    .zero     (to_zero)
  );

  // A decision arriving on the expiry cycle wins over the timeout.
  assign expire = (state == ST_WAIT) && to_zero && !cmp_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_timeout <= 1'b0;
    end else if (expire) begin
      cmp_timeout <= 1'b1;
    end
  end
`else
  assign expire = 1'b0;
`endif

  // A timed-out bit resolves to 0 because cmp_valid is low on expiry.
  assign decide  = (state == ST_WAIT) && (cmp_valid || expire);
  assign bit_val = cmp_valid & cmp_out;

  // Current code with bit k resolved, and the same with the next trial bit set.
  always_comb begin
    sar_decided          = sar;
    sar_decided[bit_idx] = bit_val;
    sar_stepped          = sar_decided;
    sar_stepped[bit_idx - IDX_W'(1)] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    next_state = state;
    phase_load = 1'b0;
    phase_val  = SETTLE_LOAD;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = ST_SAMPLE;
          phase_load = 1'b1;
          phase_val  = SAMPLE_LOAD;
        end
      end
      ST_SAMPLE: begin
        if (phase_zero) begin
          next_state = ST_SETTLE;
          phase_load = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (phase_zero) next_state = ST_STROBE;
      end
      ST_STROBE: next_state = ST_WAIT;
      ST_WAIT: begin
        if (decide) begin
          if (bit_idx == '0) begin
            next_state = ST_DONE;
          end else begin
            next_state = ST_SETTLE;
            phase_load = 1'b1;
          end
        end
      end
      ST_DONE: begin
        // The handshake completes before any new start is considered.
        if (dout_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Control outputs are registered from next_state so the strobe and switch
  // enables leave a flop cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      samp_en <= 1'b0;
      cmp_clk <= 1'b0;
    end else begin
      state   <= next_state;
      busy    <= (next_state != ST_IDLE);
      samp_en <= (next_state == ST_SAMPLE);
      cmp_clk <= (next_state == ST_STROBE);
    end
  end

  // ---------------------------------------------------------------------------
  // SAR register and result
  // ---------------------------------------------------------------------------
  // NOTE: the SAR code and result are plain registers, not a memory, so all of
  // them are cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sar        <= '0;
      bit_idx    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: sar <= '0;
        ST_SAMPLE: begin
          if (next_state == ST_SETTLE) begin
            sar[N_BITS-1] <= 1'b1;
            bit_idx       <= MSB_IDX;
          end
        end
        ST_WAIT: begin
          if (decide) begin
            if (bit_idx != '0) begin
              sar     <= sar_stepped;
              bit_idx <= bit_idx - IDX_W'(1);
            end else begin
              sar        <= sar_decided;
              dout       <= sar_decided;
              dout_valid <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (dout_ready) dout_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Bottom-plate drive: SAR code from SETTLE through DONE, zero otherwise.
  // Bits at and above N_BITS stay 0.
  // ---------------------------------------------------------------------------
  assign drive_plates = (state == ST_SETTLE) || (state == ST_STROBE) ||
                        (state == ST_WAIT)   || (state == ST_DONE);

  always_comb begin
    cap_botplate_main = '0;
    cap_botplate_diff = '0;
    if (drive_plates) begin
      cap_botplate_main[N_BITS-1:0] = sar;
      cap_botplate_diff[N_BITS-1:0] = ~sar;
    end
  end

endmodule

// File: tb/tb_sar_logic.sv
// -----------------------------------------------------------------------------
// tb_sar_logic
// Self-checking bench for sar_logic. Two instances: default (16 bits) and a
// 10-bit build. A behavioural comparator compares the DAC code presented at
// each strobe against an analog target and answers one cycle later; expected
// codes come from a plain binary-search reference. Define SAR_CMP_TIMEOUT_EN
// to also exercise the comparator watchdog.
// -----------------------------------------------------------------------------
module tb_sar_logic;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        a_start, a_busy, a_samp_en, a_cmp_clk, a_cmp_valid, a_cmp_out;
  logic [15:0] a_main, a_diff, a_dout;
  logic        a_dout_valid, a_dout_ready;
  // 10-bit instance
  logic        b_start, b_busy, b_samp_en, b_cmp_clk, b_cmp_valid, b_cmp_out;
  logic [15:0] b_main, b_diff;
  logic [9:0]  b_dout;
  logic        b_dout_valid, b_dout_ready;
`ifdef SAR_CMP_TIMEOUT_EN
  logic        a_cmp_timeout, b_cmp_timeout;
`endif

  sar_logic #(.N_BITS(16)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .samp_en(a_samp_en),
    .cap_botplate_main(a_main), .cap_botplate_diff(a_diff), .cmp_clk(a_cmp_clk),
    .cmp_valid(a_cmp_valid), .cmp_out(a_cmp_out), .dout(a_dout),
    .dout_valid(a_dout_valid), .dout_ready(a_dout_ready)
`ifdef SAR_CMP_TIMEOUT_EN
    , .cmp_timeout(a_cmp_timeout)
`endif
  );

  sar_logic #(.N_BITS(10)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .samp_en(b_samp_en),
    .cap_botplate_main(b_main), .cap_botplate_diff(b_diff), .cmp_clk(b_cmp_clk),
    .cmp_valid(b_cmp_valid), .cmp_out(b_cmp_out), .dout(b_dout),
    .dout_valid(b_dout_valid), .dout_ready(b_dout_ready)
`ifdef SAR_CMP_TIMEOUT_EN
    , .cmp_timeout(b_cmp_timeout)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Comparator model: 0 = compare against target, 1 = always 0, 2 = always 1
  int          mode;
  logic [15:0] tgt_a, tgt_b;
  bit          a_sup_msb;
  bit          a_pend_v, a_pend_o, b_pend_v, b_pend_o;
  int          a_strobes, b_strobes, a_plate_err, b_plate_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit cmp_model(input logic [15:0] bus, input logic [15:0] tgt, input int n);
    int mask;
    mask = (1 << n) - 1;
    if (mode == 1) return 1'b0;
    if (mode == 2) return 1'b1;
    return ((int'(bus) & mask) <= int'(tgt));
  endfunction

  // Binary search by successive halving; optionally the MSB is forced to 0.
  function automatic logic [15:0] ref_code(input logic [15:0] tgt, input int n, input bit sup_msb);
    int code, trial;
    code = 0;
    for (int i = n - 1; i >= 0; i--) begin
      trial = code | (1 << i);
      if (!(sup_msb && i == n - 1) && trial <= int'(tgt)) code = trial;
    end
    return 16'(code);
  endfunction

  // Advance one cycle, sample 1 time unit after the edge, run comparator models.
  task automatic tick();
    @(posedge clk);
    #1;
    a_cmp_valid = a_pend_v | (a_samp_en & 1'($urandom_range(0, 1)));
    a_cmp_out   = a_pend_v ? a_pend_o : 1'($urandom_range(0, 1));
    b_cmp_valid = b_pend_v | (b_samp_en & 1'($urandom_range(0, 1)));
    b_cmp_out   = b_pend_v ? b_pend_o : 1'($urandom_range(0, 1));
    a_pend_v = 1'b0;
    b_pend_v = 1'b0;
    if (a_cmp_clk) begin
      a_strobes++;
      a_pend_v = !(a_sup_msb && a_strobes == 1);
      a_pend_o = cmp_model(a_main, tgt_a, 16);
    end
    if (b_cmp_clk) begin
      b_strobes++;
      b_pend_v = 1'b1;
      b_pend_o = cmp_model(b_main, tgt_b, 10);
    end
    if (a_busy && !a_samp_en) begin
      if (a_diff !== ~a_main) a_plate_err++;
    end else if (a_main !== 16'h0 || a_diff !== 16'h0) a_plate_err++;
    if (b_main[15:10] !== 6'h0 || b_diff[15:10] !== 6'h0) b_plate_err++;
    if (b_busy && !b_samp_en) begin
      if (b_diff[9:0] !== ~b_main[9:0]) b_plate_err++;
    end else if (b_main !== 16'h0 || b_diff !== 16'h0) b_plate_err++;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_busy"}, a_busy, 0);
    check({tag, "_samp_en"}, a_samp_en, 0);
    check({tag, "_cmp_clk"}, a_cmp_clk, 0);
    check({tag, "_dout_valid"}, a_dout_valid, 0);
    check({tag, "_dout"}, a_dout, 0);
    check({tag, "_main"}, a_main, 0);
    check({tag, "_diff"}, a_diff, 0);
`ifdef SAR_CMP_TIMEOUT_EN
    check({tag, "_timeout"}, a_cmp_timeout, 0);
`endif
  endtask

  // One conversion on instance sel (0 = 16-bit, 1 = 10-bit).
  task automatic conv(input bit sel, input logic [15:0] exp_code, input int exp_lat,
                      input int hold, input bit poke, input int abort_at,
                      input bit start_with_ready, input string tag);
    int cyc;
    bit prev_clk, cur_clk;
    if (!sel) begin a_strobes = 0; a_plate_err = 0; a_start = 1'b1; end
    else      begin b_strobes = 0; b_plate_err = 0; b_start = 1'b1; end
    tick();
    a_start = 1'b0;
    b_start = 1'b0;
    cyc = 1;
    prev_clk = 1'b0;
    while (!(sel ? b_dout_valid : a_dout_valid) && cyc < 400) begin
      tick();
      cyc++;
      cur_clk = sel ? b_cmp_clk : a_cmp_clk;
      // The cycle after a strobe is WAIT: a start there must be ignored.
      if (sel) b_start = poke && prev_clk; else a_start = poke && prev_clk;
      prev_clk = cur_clk;
      if (abort_at > 0 && (sel ? b_strobes : a_strobes) == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_a({tag, "_abort"});
        return;
      end
    end
    a_start = 1'b0;
    b_start = 1'b0;
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_valid"}, sel ? b_dout_valid : a_dout_valid, 1);
    check({tag, "_dout"}, sel ? {6'h0, b_dout} : a_dout, exp_code);
    check({tag, "_strobes"}, sel ? b_strobes : a_strobes, sel ? 10 : 16);
    check({tag, "_plates"}, sel ? b_plate_err : a_plate_err, 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, sel ? b_dout_valid : a_dout_valid, 1);
      check({tag, "_hold_dout"}, sel ? {6'h0, b_dout} : a_dout, exp_code);
    end
    if (sel) begin b_dout_ready = 1'b1; b_start = start_with_ready; end
    else     begin a_dout_ready = 1'b1; a_start = start_with_ready; end
    tick();
    a_dout_ready = 1'b0; b_dout_ready = 1'b0;
    a_start = 1'b0;      b_start = 1'b0;
    check({tag, "_busy_after"}, sel ? b_busy : a_busy, 0);
    check({tag, "_valid_after"}, sel ? b_dout_valid : a_dout_valid, 0);
    check({tag, "_dout_kept"}, sel ? {6'h0, b_dout} : a_dout, exp_code);
    if (poke || start_with_ready) begin
      tick();
      tick();
      check({tag, "_no_queue"}, sel ? b_busy : a_busy, 0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] t;
    rst = 1'b1;
    a_start = 0; a_cmp_valid = 0; a_cmp_out = 0; a_dout_ready = 0;
    b_start = 0; b_cmp_valid = 0; b_cmp_out = 0; b_dout_ready = 0;
    mode = 0; tgt_a = 0; tgt_b = 0; a_sup_msb = 0;
    a_pend_v = 0; a_pend_o = 0; b_pend_v = 0; b_pend_o = 0;
    a_strobes = 0; b_strobes = 0; a_plate_err = 0; b_plate_err = 0;
    repeat (3) tick();
    check_reset_a("reset");
    check("reset_b_busy", b_busy, 0);
    check("reset_b_main", b_main, 0);
    rst = 1'b0;
    tick();

    // Reference conversion with defaults
    mode = 0; tgt_a = 16'h5A3C;
    conv(0, 16'h5A3C, 69, 0, 0, 0, 0, "code_5a3c");

    // Extreme comparator behaviour
    mode = 1;
    conv(0, 16'h0000, 69, 0, 0, 0, 0, "all_zero");
    mode = 2;
    conv(0, 16'hFFFF, 69, 0, 0, 0, 0, "all_one");

    // Random analog levels
    mode = 0;
    for (int i = 0; i < 3; i++) begin
      tgt_a = 16'($urandom);
      conv(0, ref_code(tgt_a, 16, 0), 69, 0, 0, 0, 0, "rand16");
    end

    // 10-bit build; start pulsed in every WAIT is ignored
    mode = 2;
    conv(1, 16'h03FF, 45, 0, 1, 0, 0, "n10_ones");
    mode = 0; tgt_b = 16'($urandom_range(0, 1023));
    conv(1, ref_code(tgt_b, 10, 0), 45, 0, 0, 0, 0, "n10_rand");

    // Reset on the third strobe, then a clean conversion
    tgt_a = 16'h1234;
    conv(0, 16'h1234, 69, 0, 0, 3, 0, "mid_reset");
    conv(0, 16'h1234, 69, 0, 0, 0, 0, "after_reset");

    // Consumer stalls 20 cycles
    tgt_a = 16'($urandom);
    conv(0, ref_code(tgt_a, 16, 0), 69, 20, 0, 0, 0, "stall");

    // start together with dout_ready in DONE is not accepted
    tgt_a = 16'hA001;
    conv(0, 16'hA001, 69, 0, 0, 0, 1, "start_in_done");

`ifdef SAR_CMP_TIMEOUT_EN
    check("timeout_clear", a_cmp_timeout, 0);
    tgt_a = 16'hC3A5; a_sup_msb = 1'b1;
    conv(0, ref_code(16'hC3A5, 16, 1), 83, 0, 0, 0, 0, "timeout_msb");
    a_sup_msb = 1'b0;
    check("timeout_set", a_cmp_timeout, 1);
    t = 16'($urandom);
    tgt_a = t;
    conv(0, ref_code(t, 16, 0), 69, 0, 0, 0, 0, "timeout_next");
    check("timeout_sticky", a_cmp_timeout, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("timeout_rst", a_cmp_timeout, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
